// File: rtl/kbd_ascii_fifo.sv
// Keyboard event decoder: turns set-2 make/break codes into ASCII, tracks modifier state,
// and buffers characters in a show-ahead FIFO for the CPU keyboard port.
`timescale 1ns/1ps
module kbd_ascii_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_code,
  input  logic       key_down,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       caps_lock,
  output logic       shift_held,
  output logic       ctrl_held
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [7:0] KC_LSHIFT = 8'h12;
  localparam logic [7:0] KC_RSHIFT = 8'h59;
  localparam logic [7:0] KC_CTRL   = 8'h14;
  localparam logic [7:0] KC_CAPS   = 8'h58;

  logic [7:0]    prev_code_q;
  logic          prev_down_q;
  logic          shift_q, shift_d;
  logic          ctrl_q, ctrl_d;
  logic          caps_q, caps_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [DEPTH];

  logic       key_event, press_ev, release_ev, is_shift_key;
  logic       map_valid, is_letter;
  logic [7:0] lower_ch, base_ch, shifted_ch, upper_ch, map_char;
  logic       push_req, push, pop;

  // The break prefix arrives as {00,x}; a zero code is never treated as a key.
  assign key_event    = (key_code != 8'h00) && ({key_code, key_down} != {prev_code_q, prev_down_q});
  assign press_ev     = key_event && key_down;
  assign release_ev   = key_event && !key_down;
  assign is_shift_key = (key_code == KC_LSHIFT) || (key_code == KC_RSHIFT);

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    map_valid  = 1'b1;
    is_letter  = 1'b0;
    lower_ch   = 8'h00;
    base_ch    = 8'h00;
    shifted_ch = 8'h00;
    unique case (key_code)
      8'h1C: begin is_letter = 1'b1; lower_ch = "a"; end
      8'h32: begin is_letter = 1'b1; lower_ch = "b"; end
      8'h21: begin is_letter = 1'b1; lower_ch = "c"; end
      8'h23: begin is_letter = 1'b1; lower_ch = "d"; end
      8'h24: begin is_letter = 1'b1; lower_ch = "e"; end
      8'h2B: begin is_letter = 1'b1; lower_ch = "f"; end
      8'h34: begin is_letter = 1'b1; lower_ch = "g"; end
      8'h33: begin is_letter = 1'b1; lower_ch = "h"; end
      8'h43: begin is_letter = 1'b1; lower_ch = "i"; end
      8'h3B: begin is_letter = 1'b1; lower_ch = "j"; end
      8'h42: begin is_letter = 1'b1; lower_ch = "k"; end
      8'h4B: begin is_letter = 1'b1; lower_ch = "l"; end
      8'h3A: begin is_letter = 1'b1; lower_ch = "m"; end
      8'h31: begin is_letter = 1'b1; lower_ch = "n"; end
      8'h44: begin is_letter = 1'b1; lower_ch = "o"; end
      8'h4D: begin is_letter = 1'b1; lower_ch = "p"; end
      8'h15: begin is_letter = 1'b1; lower_ch = "q"; end
      8'h2D: begin is_letter = 1'b1; lower_ch = "r"; end
      8'h1B: begin is_letter = 1'b1; lower_ch = "s"; end
      8'h2C: begin is_letter = 1'b1; lower_ch = "t"; end
      8'h3C: begin is_letter = 1'b1; lower_ch = "u"; end
      8'h2A: begin is_letter = 1'b1; lower_ch = "v"; end
      8'h1D: begin is_letter = 1'b1; lower_ch = "w"; end
      8'h22: begin is_letter = 1'b1; lower_ch = "x"; end
      8'h35: begin is_letter = 1'b1; lower_ch = "y"; end
      8'h1A: begin is_letter = 1'b1; lower_ch = "z"; end
      8'h45: begin base_ch = 8'h30; shifted_ch = 8'h29; end
      8'h16: begin base_ch = 8'h31; shifted_ch = 8'h21; end
      8'h1E: begin base_ch = 8'h32; shifted_ch = 8'h40; end
      8'h26: begin base_ch = 8'h33; shifted_ch = 8'h23; end
      8'h25: begin base_ch = 8'h34; shifted_ch = 8'h24; end
      8'h2E: begin base_ch = 8'h35; shifted_ch = 8'h25; end
      8'h36: begin base_ch = 8'h36; shifted_ch = 8'h5E; end
      8'h3D: begin base_ch = 8'h37; shifted_ch = 8'h26; end
      8'h3E: begin base_ch = 8'h38; shifted_ch = 8'h2A; end
      8'h46: begin base_ch = 8'h39; shifted_ch = 8'h28; end
      8'h4E: begin base_ch = 8'h2D; shifted_ch = 8'h5F; end
      8'h55: begin base_ch = 8'h3D; shifted_ch = 8'h2B; end
      8'h54: begin base_ch = 8'h5B; shifted_ch = 8'h7B; end
      8'h5B: begin base_ch = 8'h5D; shifted_ch = 8'h7D; end
      8'h4C: begin base_ch = 8'h3B; shifted_ch = 8'h3A; end
      8'h52: begin base_ch = 8'h27; shifted_ch = 8'h22; end
      8'h41: begin base_ch = 8'h2C; shifted_ch = 8'h3C; end
      8'h49: begin base_ch = 8'h2E; shifted_ch = 8'h3E; end
      8'h4A: begin base_ch = 8'h2F; shifted_ch = 8'h3F; end
      8'h0E: begin base_ch = 8'h60; shifted_ch = 8'h7E; end
      8'h29: begin base_ch = 8'h20; shifted_ch = 8'h20; end
      8'h5A: begin base_ch = 8'h0A; shifted_ch = 8'h0A; end
      8'h66: begin base_ch = 8'h08; shifted_ch = 8'h08; end
      8'h0D: begin base_ch = 8'h09; shifted_ch = 8'h09; end
      default: map_valid = 1'b0;
    endcase
  end

  // Mapping uses the modifier state registered before this edge.
  assign upper_ch = lower_ch & 8'hDF;
  always_comb begin
    map_char = shift_q ? shifted_ch : base_ch;
    if (is_letter) begin
      if (ctrl_q)                map_char = upper_ch & 8'h1F;
      else if (shift_q ^ caps_q) map_char = upper_ch;
      else                       map_char = lower_ch;
    end
  end

  always_comb begin
    shift_d = shift_q;
    ctrl_d  = ctrl_q;
    caps_d  = caps_q;
    if (is_shift_key && press_ev)        shift_d = 1'b1;
    if (is_shift_key && release_ev)      shift_d = 1'b0;
    if (key_code == KC_CTRL && press_ev)   ctrl_d = 1'b1;
    if (key_code == KC_CTRL && release_ev) ctrl_d = 1'b0;
    if (key_code == KC_CAPS && press_ev)   caps_d = !caps_q;
  end

  // A full FIFO still accepts a push when the same edge pops the head.
  assign pop      = rd_en && (count_q != '0);
  assign push_req = press_ev && map_valid;
  assign push     = push_req && ((count_q != FULL_COUNT) || pop);

  always_comb begin
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    overflow_d = overflow_q || (push_req && !push);
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_code_q <= 8'h00;
      prev_down_q <= 1'b0;
      shift_q     <= 1'b0;
      ctrl_q      <= 1'b0;
      caps_q      <= 1'b0;
      overflow_q  <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      prev_code_q <= key_code;
      prev_down_q <= key_down;
      shift_q     <= shift_d;
      ctrl_q      <= ctrl_d;
      caps_q      <= caps_d;
      overflow_q  <= overflow_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  // NOTE: storage is not reset; count gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= map_char;
  end

  assign rd_data    = (count_q == '0) ? 8'h00 : mem_q[rd_ptr_q];
  assign empty      = (count_q == '0);
  assign full       = (count_q == FULL_COUNT);
  assign overflow   = overflow_q;
  assign caps_lock  = caps_q;
  assign shift_held = shift_q;
  assign ctrl_held  = ctrl_q;

endmodule

// File: tb/tb_kbd_ascii_fifo.sv
// Self-checking bench for kbd_ascii_fifo: a vector table for key/modifier mapping plus
// hand-written sequences for FIFO full, overflow, simultaneous push/pop and reset.
`timescale 1ns/1ps
module tb_kbd_ascii_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key_code;
  logic       key_down;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty, full, overflow, caps_lock, shift_held, ctrl_held;

  kbd_ascii_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_code   (key_code),
    .key_down   (key_down),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .caps_lock  (caps_lock),
    .shift_held (shift_held),
    .ctrl_held  (ctrl_held)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       down;
    logic       push;
    logic [7:0] ch;
    logic       shift;
    logic       ctrl;
    logic       caps;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb_q[$];
  logic [7:0] letters[26];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] c, input logic d, input logic r);
    key_code = c;
    key_down = d;
    rd_en    = r;
    tick();
    rd_en    = 1'b0;
  endtask

  task automatic add(input logic [7:0] c, input logic d, input logic p, input logic [7:0] ch,
                     input logic sh, input logic ct, input logic cp);
    vec_t v;
    v.code = c; v.down = d; v.push = p; v.ch = ch; v.shift = sh; v.ctrl = ct; v.caps = cp;
    vecs.push_back(v);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " empty"},    {7'd0, empty},      8'd1);
    check({tag, " full"},     {7'd0, full},       8'd0);
    check({tag, " overflow"}, {7'd0, overflow},   8'd0);
    check({tag, " caps"},     {7'd0, caps_lock},  8'd0);
    check({tag, " shift"},    {7'd0, shift_held}, 8'd0);
    check({tag, " ctrl"},     {7'd0, ctrl_held},  8'd0);
    check({tag, " rd_data"},  rd_data,            8'h00);
  endtask

  // Pops every character the scoreboard expects, comparing the show-ahead head each time.
  task automatic drain(input string tag);
    while (sb_q.size() != 0) begin
      check({tag, " rd_data"}, rd_data, sb_q.pop_front());
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    check({tag, " empty after drain"}, {7'd0, empty}, 8'd1);
    check({tag, " rd_data empty"},     rd_data,       8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    letters = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    rst = 1'b1; key_code = 8'h00; key_down = 1'b0; rd_en = 1'b0;
    tick();
    tick();
    check_reset_state("reset");
    rst = 1'b0;

    //   code   dn  push ch     sh ct cp
    add(8'h1C, 1, 1, 8'h61, 0, 0, 0);  // 'a'
    add(8'h00, 1, 0, 8'h00, 0, 0, 0);  // break prefix
    add(8'h1C, 0, 0, 8'h00, 0, 0, 0);
    add(8'h12, 1, 0, 8'h00, 1, 0, 0);
    add(8'h16, 1, 1, 8'h21, 1, 0, 0);  // '!'
    add(8'h16, 0, 0, 8'h00, 1, 0, 0);
    add(8'h12, 0, 0, 8'h00, 0, 0, 0);
    add(8'h16, 1, 1, 8'h31, 0, 0, 0);  // '1'
    add(8'h16, 0, 0, 8'h00, 0, 0, 0);
    add(8'h58, 1, 0, 8'h00, 0, 0, 1);
    add(8'h58, 0, 0, 8'h00, 0, 0, 1);
    add(8'h1C, 1, 1, 8'h41, 0, 0, 1);  // 'A' via caps
    add(8'h1C, 0, 0, 8'h00, 0, 0, 1);
    add(8'h12, 1, 0, 8'h00, 1, 0, 1);
    add(8'h1C, 1, 1, 8'h61, 1, 0, 1);  // shift^caps -> 'a'
    add(8'h1C, 1, 0, 8'h00, 1, 0, 1);  // held key, no repeat
    add(8'h1C, 0, 0, 8'h00, 1, 0, 1);
    add(8'h12, 0, 0, 8'h00, 0, 0, 1);
    add(8'h58, 1, 0, 8'h00, 0, 0, 0);
    add(8'h58, 0, 0, 8'h00, 0, 0, 0);
    add(8'h14, 1, 0, 8'h00, 0, 1, 0);
    add(8'h21, 1, 1, 8'h03, 0, 1, 0);  // ctrl-c
    add(8'h21, 0, 0, 8'h00, 0, 1, 0);
    add(8'h14, 0, 0, 8'h00, 0, 0, 0);
    add(8'h29, 1, 1, 8'h20, 0, 0, 0);  // space
    add(8'h29, 0, 0, 8'h00, 0, 0, 0);
    add(8'h59, 1, 0, 8'h00, 1, 0, 0);
    add(8'h4E, 1, 1, 8'h5F, 1, 0, 0);  // '_'
    add(8'h4E, 0, 0, 8'h00, 1, 0, 0);
    add(8'h59, 0, 0, 8'h00, 0, 0, 0);
    add(8'h0E, 1, 1, 8'h60, 0, 0, 0);  // '`'
    add(8'h76, 1, 0, 8'h00, 0, 0, 0);  // unmapped code
    add(8'h1A, 1, 1, 8'h7A, 0, 0, 0);  // 'z'
    add(8'h5A, 1, 1, 8'h0A, 0, 0, 0);  // enter
    add(8'h5A, 0, 0, 8'h00, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].code, vecs[i].down, 1'b0);
      if (vecs[i].push) sb_q.push_back(vecs[i].ch);
      check($sformatf("vec%0d shift", i), {7'd0, shift_held}, {7'd0, vecs[i].shift});
      check($sformatf("vec%0d ctrl", i),  {7'd0, ctrl_held},  {7'd0, vecs[i].ctrl});
      check($sformatf("vec%0d caps", i),  {7'd0, caps_lock},  {7'd0, vecs[i].caps});
      check($sformatf("vec%0d empty", i), {7'd0, empty},      {7'd0, sb_q.size() == 0});
      check($sformatf("vec%0d head", i),  rd_data,            sb_q[0]);
    end
    drain("table");

    // Fill to exactly DEPTH, then push and pop together while full.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(letters[i], 1'b1, 1'b0);
      sb_q.push_back(8'h61 + 8'(i));
    end
    check("fill full",     {7'd0, full},     8'd1);
    check("fill overflow", {7'd0, overflow}, 8'd0);
    check("fill empty",    {7'd0, empty},    8'd0);
    check("pushpop head",  rd_data,          sb_q.pop_front());
    drive(letters[16], 1'b1, 1'b1);
    sb_q.push_back(8'h71);
    check("pushpop full",     {7'd0, full},     8'd1);
    check("pushpop overflow", {7'd0, overflow}, 8'd0);
    check("pushpop new head", rd_data,          8'h62);

    // Two more presses with no read are dropped.
    drive(letters[17], 1'b1, 1'b0);
    check("drop1 overflow", {7'd0, overflow}, 8'd1);
    drive(letters[18], 1'b1, 1'b0);
    check("drop2 full",     {7'd0, full},     8'd1);
    drain("full");
    check("overflow sticky", {7'd0, overflow}, 8'd1);

    drive(letters[18], 1'b1, 1'b1);
    check("pop empty empty", {7'd0, empty}, 8'd1);
    check("pop empty full",  {7'd0, full},  8'd0);
    drive(letters[0], 1'b1, 1'b0);
    check("after empty pop head",  rd_data,       8'h61);
    check("after empty pop empty", {7'd0, empty}, 8'd0);

    // Reset mid-stream with Shift down and a key held across reset.
    drive(8'h12, 1'b1, 1'b0);
    drive(8'h32, 1'b1, 1'b0);
    check("pre-reset shift", {7'd0, shift_held}, 8'd1);
    sb_q.delete();
    do_reset();
    check_reset_state("midreset");
    tick();
    check("held across reset empty", {7'd0, empty}, 8'd0);
    check("held across reset char",  rd_data,       8'h62);
    sb_q.push_back(8'h62);
    drain("post-reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
